seg_scan_mux: RTL and testbench

Time-multiplexed driver for the six-digit seven-segment display on the adder board. It sits directly downstream of the 4-bit adder's display decode. It takes the six active-low 8-bit segment patterns for the A, B and Sum ones/tens digits and drives one shared segment bus plus six active-low digit anodes, one digit at a time. Each digit slot starts with a blanking gap to suppress ghosting. Input patterns are captured once per frame so the display never tears mid-scan.

---
 rtl/seg_scan_pkg.sv | 28 ++
 rtl/seg_scan_timer.sv | 33 +++
 rtl/seg_scan_mux.sv | 112 +++++++++++
 tb/tb_seg_scan_mux.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants, state encoding and helpers for the six-digit display scanner.
package seg_scan_pkg;

    localparam logic [7:0] SEG_OFF    = 8'hff;
    localparam logic [5:0] AN_OFF     = 6'h3f;
    localparam int         NUM_DIGITS = 6;

    // Digit positions on the shared bus, in scan order.
    localparam logic [2:0] DIG_ONES  = 3'd0;
    localparam logic [2:0] DIG_TENS  = 3'd1;
    localparam logic [2:0] DIG_BONES = 3'd2;
    localparam logic [2:0] DIG_BTENS = 3'd3;
    localparam logic [2:0] DIG_AONES = 3'd4;
    localparam logic [2:0] DIG_ATENS = 3'd5;

    // Scanner states: idle, blanking gap at slot start, driving one digit.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } scan_state_t;

    // Active-low anode vector with only digit d enabled.
    function automatic logic [5:0] digit_anode(input logic [2:0] d);
        return ~(6'b000001 << d);
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Per-slot cycle counter; flags the end of the blanking gap and the end of the slot.
module seg_scan_timer #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic blank_end,
    output logic slot_end
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    // Count through the slot, restarting at slot end or while the scanner is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign blank_end = (cnt == BLANK_LAST);
    assign slot_end  = (cnt == SLOT_LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Six-digit seven-segment scanner: one digit per slot, blank gap first,
// patterns latched once per frame so a frame is never torn.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] ones,
    input  logic [7:0] tens,
    input  logic [7:0] Bones,
    input  logic [7:0] Btens,
    input  logic [7:0] Aones,
    input  logic [7:0] Atens,
    output logic [7:0] seg,
    output logic [5:0] an,
    output logic       frame_done
);

    scan_state_t state;
    logic [2:0]  d;
    logic [7:0]  pattern [NUM_DIGITS];
    logic [7:0]  shadow  [NUM_DIGITS];
    logic        blank_end;
    logic        slot_end;

    // Present the inputs as an array indexed by digit position.
    assign pattern[DIG_ONES]  = ones;
    assign pattern[DIG_TENS]  = tens;
    assign pattern[DIG_BONES] = Bones;
    assign pattern[DIG_BTENS] = Btens;
    assign pattern[DIG_AONES] = Aones;
    assign pattern[DIG_ATENS] = Atens;

    seg_scan_timer #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == S_IDLE),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    // Scan FSM with registered outputs; shadow copies refresh only at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
            d          <= DIG_ONES;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= SEG_OFF;
            end
        end else begin
            frame_done <= 1'b0;
            if (!en) begin
                state <= S_IDLE;
                seg   <= SEG_OFF;
                an    <= AN_OFF;
                d     <= DIG_ONES;
            end else begin
                case (state)
                    S_IDLE: begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            shadow[i] <= pattern[i];
                        end
                        d     <= DIG_ONES;
                        seg   <= SEG_OFF;
                        an    <= AN_OFF;
                        state <= S_BLANK;
                    end
                    S_BLANK: begin
                        if (blank_end) begin
                            seg   <= shadow[d];
                            an    <= digit_anode(d);
                            state <= S_DRIVE;
                        end
                    end
                    S_DRIVE: begin
                        if (slot_end) begin
                            seg   <= SEG_OFF;
                            an    <= AN_OFF;
                            state <= S_BLANK;
                            if (d == DIG_ATENS) begin
                                d          <= DIG_ONES;
                                frame_done <= 1'b1;
                                for (int i = 0; i < NUM_DIGITS; i++) begin
                                    shadow[i] <= pattern[i];
                                end
                            end else begin
                                d <= d + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        seg   <= SEG_OFF;
                        an    <= AN_OFF;
                        d     <= DIG_ONES;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a frame-level model predicts each cycle's
// outputs, a negedge monitor compares them and checks display invariants.
module tb_seg_scan_mux;
    import seg_scan_pkg::*;

    localparam int P     = 4;
    localparam int BL    = 1;
    localparam int FRAME = P * NUM_DIGITS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] ones = 8'h00, tens = 8'h00, bones = 8'h00;
    logic [7:0] btens = 8'h00, aones = 8'h00, atens = 8'h00;
    logic [7:0] seg;
    logic [5:0] an;
    logic       frame_done;

    seg_scan_mux #(.PRESCALE(P), .BLANK(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ones       (ones),
        .tens       (tens),
        .Bones      (bones),
        .Btens      (btens),
        .Aones      (aones),
        .Atens      (atens),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [5:0] an;
        logic       fd;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    bit         model_active = 1'b0;
    int         model_t = 0;
    logic [7:0] model_pat [NUM_DIGITS];

    task automatic capture();
        model_pat[0] = ones;
        model_pat[1] = tens;
        model_pat[2] = bones;
        model_pat[3] = btens;
        model_pat[4] = aones;
        model_pat[5] = atens;
    endtask

    // Predict the outputs after the coming edge from time since enable, then take the edge.
    task automatic step();
        exp_t e;
        int   pos;
        int   digit;
        e.seg = SEG_OFF;
        e.an  = AN_OFF;
        e.fd  = 1'b0;
        if (!rst_n || !en) begin
            model_active = 1'b0;
        end else if (!model_active) begin
            model_active = 1'b1;
            model_t      = 0;
            capture();
        end else begin
            model_t++;
            if (model_t % FRAME == 0) begin
                capture();
                e.fd = 1'b1;
            end
            pos   = model_t % P;
            digit = (model_t / P) % NUM_DIGITS;
            if (pos >= BL) begin
                e.seg = model_pat[digit];
                e.an  = ~(6'b000001 << digit);
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic bit driving_digit(input int dg);
        return model_active && (model_t % P >= BL) && (dg < 0 || (model_t / P) % NUM_DIGITS == dg);
    endfunction

    // Monitor: compare each cycle against the scoreboard and check display invariants.
    exp_t       mon_e;
    logic [7:0] prev_seg = SEG_OFF;
    logic [5:0] prev_an  = AN_OFF;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (seg !== mon_e.seg) begin
                failures++;
                $display("FAIL seg t=%0t got=%h want=%h", $time, seg, mon_e.seg);
            end
            checks++;
            if (an !== mon_e.an) begin
                failures++;
                $display("FAIL an t=%0t got=%b want=%b", $time, an, mon_e.an);
            end
            checks++;
            if (frame_done !== mon_e.fd) begin
                failures++;
                $display("FAIL frame_done t=%0t got=%b want=%b", $time, frame_done, mon_e.fd);
            end
        end
        checks++;
        if ($countones(~an) > 1) begin
            failures++;
            $display("FAIL one_anode t=%0t got an=%b want at most one low", $time, an);
        end
        if (prev_an != AN_OFF && an == prev_an) begin
            checks++;
            if (seg !== prev_seg) begin
                failures++;
                $display("FAIL seg_stable t=%0t got=%h want=%h", $time, seg, prev_seg);
            end
        end
        prev_seg = seg;
        prev_an  = an;
    end

    initial begin
        // Reset, then hold disabled.
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();

        // Basic scan across three frames, with a mid-frame change to the ones digit.
        ones = 8'h49; tens = 8'h9f; bones = 8'h99;
        btens = 8'hff; aones = 8'h9f; atens = 8'h9f;
        en = 1'b1;
        for (int i = 0; i < 72; i++) begin
            if (i == 34) ones = 8'h03;
            step();
            $display("cycle t=%0d seg=%h an=%b fd=%b", model_t, seg, an, frame_done);
        end

        // Disable while digit 3 is being driven, then re-enable.
        for (int k = 0; k < 100 && !driving_digit(3); k++) step();
        checks++;
        if (!driving_digit(3)) begin
            failures++;
            $display("FAIL find_digit3 got=not_reached want=digit3_driven");
        end
        en = 1'b0;
        step();
        $display("disable seg=%h an=%b fd=%b", seg, an, frame_done);
        repeat (3) step();
        en = 1'b1;
        repeat (10) step();

        // Asynchronous reset between edges while a digit is lit.
        for (int k = 0; k < 100 && !driving_digit(-1); k++) step();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== AN_OFF) begin
            failures++;
            $display("FAIL async_an got=%b want=%b", an, AN_OFF);
        end
        checks++;
        if (seg !== SEG_OFF) begin
            failures++;
            $display("FAIL async_seg got=%h want=%h", seg, SEG_OFF);
        end
        $display("async_reset seg=%h an=%b", seg, an);
        if (exp_q.size() > 0) exp_q[exp_q.size()-1] = {SEG_OFF, AN_OFF, 1'b0};
        model_active = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Random frames with random inputs and occasional disable.
        for (int i = 0; i < 10 * FRAME; i++) begin
            ones  = 8'($urandom); tens  = 8'($urandom); bones = 8'($urandom);
            btens = 8'($urandom); aones = 8'($urandom); atens = 8'($urandom);
            en = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            step();
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
